// File: rtl/apb_pkg.sv
// Shared types and protocol constants for the APB requester and its helpers.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam logic APB_WRITE = 1'b1;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags when the last permitted one is reached.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on ACCESS entry, saturate at LAST, frozen when timeout is disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (TIMEOUT != 0) && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/apb_master_mux.sv
// APB4 requester: valid/ready command port to NUM_SLV completers with
// address decode, wait-state timeout and back-to-back transfers.
module apb_master_mux #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_W   = 3,
    parameter int SEL_LSB = 28,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [DATA_W/8-1:0]       req_strb,
    input  logic                      req_write,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);
    import apb_pkg::*;

    localparam logic [SEL_W:0] NUM_SLV_W = (SEL_W + 1)'(NUM_SLV);

    apb_state_t state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d, req_sel_s;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d, prdata_s, rsp_rdata_q, rsp_rdata_d;
    logic [DATA_W/8-1:0] pstrb_q, pstrb_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic                req_sel_ok_s, acc_s, load_s, done_s, dec_err_s, timeout_s;
    logic                pready_s, pslverr_s, expired_s;

    assign req_sel_s    = req_addr[SEL_LSB +: SEL_W];
    assign req_sel_ok_s = ({1'b0, req_sel_s} < NUM_SLV_W);

    // Steer the selected completer's ready/error/data; other completers are ignored.
    always_comb begin
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
        prdata_s  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            pready_s  = pready_s  | (PREADY[i]  & (sel_q == SEL_W'(i)));
            pslverr_s = pslverr_s | (PSLVERR[i] & (sel_q == SEL_W'(i)));
            prdata_s  = prdata_s  | (PRDATA[i*DATA_W +: DATA_W] & {DATA_W{sel_q == SEL_W'(i)}});
        end
    end

    // A decode-error request offered at an ACCESS completion waits for IDLE,
    // so two responses never collide in the same cycle.
    always_comb begin
        case (state_q)
            IDLE:    req_ready = 1'b1;
            ACCESS:  req_ready = pready_s && req_sel_ok_s;
            default: req_ready = 1'b0;
        endcase
    end

    assign acc_s     = req_valid && req_ready;
    assign load_s    = acc_s && req_sel_ok_s;
    assign dec_err_s = acc_s && !req_sel_ok_s;
    assign done_s    = (state_q == ACCESS) && pready_s;
    assign timeout_s = (state_q == ACCESS) && !pready_s && expired_s;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .clr_i     (state_q == SETUP),
        .en_i      ((state_q == ACCESS) && !pready_s),
        .expired_o (expired_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load_s) state_d = SETUP;
                else        state_d = IDLE;
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (done_s)         state_d = load_s ? SETUP : IDLE;
                else if (timeout_s) state_d = IDLE;
                else                state_d = ACCESS;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next-values; bus outputs follow state_d so they line up with state_q.
    always_comb begin
        sel_d       = load_s ? req_sel_s : sel_q;
        paddr_d     = load_s ? req_addr  : paddr_q;
        pwdata_d    = load_s ? req_wdata : pwdata_q;
        pwrite_d    = load_s ? req_write : pwrite_q;
        pstrb_d     = load_s ? ((req_write == APB_WRITE) ? req_strb : '0) : pstrb_q;
        penable_d   = (state_d == ACCESS);
        for (int i = 0; i < NUM_SLV; i++) begin
            psel_d[i] = (state_d != IDLE) && (sel_d == SEL_W'(i));
        end
        rsp_valid_d = done_s || timeout_s || dec_err_s;
        rsp_err_d   = (done_s && pslverr_s) || timeout_s || dec_err_s;
        rsp_rdata_d = (done_s && (pwrite_q != APB_WRITE) && !pslverr_s) ? prdata_s : '0;
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            sel_q       <= sel_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_mux.sv
// Directed bench for apb_master_mux: one task per scenario with inline checks.
module tb_apb_master_mux;

    localparam int ADDR_W = 32, DATA_W = 32, NUM_SLV = 4, SEL_W = 3, SEL_LSB = 28, TIMEOUT = 16;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      req_valid, req_ready, req_write;
    logic [ADDR_W-1:0]         req_addr;
    logic [DATA_W-1:0]         req_wdata;
    logic [DATA_W/8-1:0]       req_strb;
    logic                      rsp_valid, rsp_err;
    logic [DATA_W-1:0]         rsp_rdata;
    logic [NUM_SLV-1:0]        PSEL;
    logic                      PENABLE, PWRITE;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic [DATA_W/8-1:0]       PSTRB;
    logic [NUM_SLV*DATA_W-1:0] PRDATA;
    logic [NUM_SLV-1:0]        PREADY, PSLVERR;

    int checks = 0;
    int errors = 0;

    apb_master_mux #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV),
        .SEL_W(SEL_W), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_write(req_write),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic w);
        req_valid = v;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        req_write = w;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        PRDATA  = '0;
        PREADY  = 4'b0000;
        PSLVERR = 4'b0000;
        step();
        step();
        checks++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 8'h00 || PADDR !== 32'h0 ||
            PWDATA !== 32'h0 || PSTRB !== 4'h0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: psel=%b pen=%b pwr=%b rv=%b re=%b paddr=%h pwdata=%h pstrb=%h rdata=%h, all must be 0",
                     PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, PADDR, PWDATA, PSTRB, rsp_rdata);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_write();
        PREADY = 4'b1111;
        set_req(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
        step();
        set_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        checks++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid} !== 7'b0010_0_1_0 || PADDR !== 32'h1000_0010 ||
            PWDATA !== 32'hDEAD_BEEF || PSTRB !== 4'hF) begin
            errors++;
            $display("FAIL wr_setup: psel=%b pen=%b pwr=%b rv=%b paddr=%h pwdata=%h pstrb=%h expected 0010/0/1/0 10000010 deadbeef f",
                     PSEL, PENABLE, PWRITE, rsp_valid, PADDR, PWDATA, PSTRB);
        end
        step();
        checks++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== 7'b0010_1_0_1) begin
            errors++;
            $display("FAIL wr_access: psel=%b pen=%b rv=%b rdy=%b expected 0010 1 0 1", PSEL, PENABLE, rsp_valid, req_ready);
        end
        step();
        checks++;
        if ({PSEL, PENABLE, rsp_valid, rsp_err} !== 7'b0000_0_1_0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wr_rsp: psel=%b pen=%b rv=%b err=%b rdata=%h expected 0000 0 1 0 0",
                     PSEL, PENABLE, rsp_valid, rsp_err, rsp_rdata);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_rsp_pulse: rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_read_wait();
        PREADY = 4'b0000;
        PRDATA = '0;
        set_req(1'b1, 32'h2000_0004, 32'hAAAA_5555, 4'hF, 1'b0);
        step();
        set_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        checks++;
        if ({PSEL, PENABLE, PWRITE} !== 6'b0100_0_0 || PSTRB !== 4'h0 || PADDR !== 32'h2000_0004) begin
            errors++;
            $display("FAIL rd_setup: psel=%b pen=%b pwr=%b pstrb=%h paddr=%h expected 0100 0 0 0 20000004",
                     PSEL, PENABLE, PWRITE, PSTRB, PADDR);
        end
        step();
        step();
        step();
        checks++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== 7'b0100_1_0_0) begin
            errors++;
            $display("FAIL rd_wait: psel=%b pen=%b rv=%b rdy=%b expected 0100 1 0 0", PSEL, PENABLE, rsp_valid, req_ready);
        end
        PREADY = 4'b0100;
        PRDATA[2*DATA_W +: DATA_W] = 32'h1234_5678;
        PRDATA[1*DATA_W +: DATA_W] = 32'hBAD0_BAD0;
        step();
        PREADY = 4'b0000;
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h1234_5678 || PSEL !== 4'b0000) begin
            errors++;
            $display("FAIL rd_rsp: rv=%b err=%b rdata=%h psel=%b expected 1 0 12345678 0000",
                     rsp_valid, rsp_err, rsp_rdata, PSEL);
        end
        step();
    endtask

    task automatic test_back_to_back();
        PREADY = 4'b1111;
        PRDATA[3*DATA_W +: DATA_W] = 32'hCAFE_F00D;
        set_req(1'b1, 32'h0000_0100, 32'h0102_0304, 4'h3, 1'b1);
        step();
        set_req(1'b1, 32'h3000_0200, 32'h0, 4'hF, 1'b0);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_setup_ready: got %b expected 0", req_ready);
        end
        step();
        checks++;
        if ({PSEL, PENABLE, req_ready} !== 6'b0001_1_1) begin
            errors++;
            $display("FAIL b2b_access1: psel=%b pen=%b rdy=%b expected 0001 1 1", PSEL, PENABLE, req_ready);
        end
        step();
        set_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        checks++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 8'b1000_0_0_1_0 || PADDR !== 32'h3000_0200 || PSTRB !== 4'h0) begin
            errors++;
            $display("FAIL b2b_setup2: psel=%b pen=%b pwr=%b rv=%b err=%b paddr=%h pstrb=%h expected 1000 0 0 1 0 30000200 0",
                     PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, PADDR, PSTRB);
        end
        step();
        checks++;
        if ({PSEL, PENABLE, rsp_valid} !== 6'b1000_1_0) begin
            errors++;
            $display("FAIL b2b_access2: psel=%b pen=%b rv=%b expected 1000 1 0", PSEL, PENABLE, rsp_valid);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL b2b_rsp2: rv=%b err=%b rdata=%h expected 1 0 cafef00d", rsp_valid, rsp_err, rsp_rdata);
        end
        step();
    endtask

    task automatic test_errors();
        set_req(1'b1, 32'h5000_0000, 32'h0, 4'hF, 1'b1);
        step();
        checks++;
        if ({PSEL, PENABLE, rsp_valid, rsp_err, req_ready} !== 8'b0000_0_1_1_1 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL dec_err1: psel=%b pen=%b rv=%b err=%b rdy=%b rdata=%h expected 0000 0 1 1 1 0",
                     PSEL, PENABLE, rsp_valid, rsp_err, req_ready, rsp_rdata);
        end
        set_req(1'b1, 32'h7000_0000, 32'h0, 4'h0, 1'b0);
        step();
        set_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        checks++;
        if ({PSEL, rsp_valid, rsp_err} !== 6'b0000_1_1) begin
            errors++;
            $display("FAIL dec_err2: psel=%b rv=%b err=%b expected 0000 1 1", PSEL, rsp_valid, rsp_err);
        end
        PREADY  = 4'b1111;
        PSLVERR = 4'b1110;
        PRDATA[0 +: DATA_W] = 32'hFFFF_FFFF;
        set_req(1'b1, 32'h0000_0040, 32'h0, 4'hF, 1'b0);
        step();
        set_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        step();
        PSLVERR = 4'b0001;
        step();
        PSLVERR = 4'b0000;
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL pslverr: rv=%b err=%b rdata=%h expected 1 1 0", rsp_valid, rsp_err, rsp_rdata);
        end
        step();
    endtask

    task automatic test_timeout();
        logic bad;
        bad    = 1'b0;
        PREADY = 4'b0000;
        PRDATA = {NUM_SLV{32'h5A5A_5A5A}};
        set_req(1'b1, 32'h1000_0000, 32'h0, 4'hF, 1'b0);
        step();
        set_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        step();
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            if (rsp_valid !== 1'b0 || PENABLE !== 1'b1) bad = 1'b1;
            step();
        end
        checks++;
        if (bad || rsp_valid !== 1'b0 || PENABLE !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: aborted before %0d ACCESS cycles (rv=%b pen=%b)", TIMEOUT, rsp_valid, PENABLE);
        end
        step();
        checks++;
        if ({PSEL, PENABLE, rsp_valid, rsp_err} !== 7'b0000_0_1_1 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_abort: psel=%b pen=%b rv=%b err=%b rdata=%h expected 0000 0 1 1 0",
                     PSEL, PENABLE, rsp_valid, rsp_err, rsp_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        PREADY = 4'b0000;
        set_req(1'b1, 32'h2000_0008, 32'h1111_2222, 4'hF, 1'b1);
        step();
        set_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        step();
        reset_n = 1'b0;
        step();
        checks++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 8'h00 || PADDR !== 32'h0 ||
            PWDATA !== 32'h0 || PSTRB !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid: psel=%b pen=%b pwr=%b rv=%b err=%b paddr=%h pwdata=%h pstrb=%h, all must be 0",
                     PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, PADDR, PWDATA, PSTRB);
        end
        reset_n = 1'b1;
        PREADY  = 4'b1111;
        step();
        checks++;
        if ({PSEL, rsp_valid, req_ready} !== 6'b0000_0_1) begin
            errors++;
            $display("FAIL reset_mid_after: psel=%b rv=%b rdy=%b expected 0000 0 1", PSEL, rsp_valid, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_errors();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_mux.md
# apb_master_mux

Parametrised APB4 requester that bridges a simple valid/ready command port to up to NUM_SLV APB completers sharing one bus. It adds address-based completer selection, byte strobes, read-data return, PSLVERR reporting, decode-error and wait-state-timeout handling, and back-to-back transfers without an idle cycle. It sits between a local bus agent (CPU/DMA) and the peripheral APB segment.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- NUM_SLV, 4, number of completers (1..2^SEL_W)
- SEL_W, 3, width of completer-select field
- SEL_LSB, 28, LSB of select field in req_addr (SEL_LSB+SEL_W <= ADDR_W)
- TIMEOUT, 16, max ACCESS cycles before abort; 0 disables timeout
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid && req_ready at clk edge
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_strb  in  DATA_W/8  write byte strobes
- req_write  in  1  1 = write, 0 = read
- rsp_valid  out  1  one-cycle response pulse, no back-pressure
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  PSLVERR, decode error or timeout
- PSEL  out  NUM_SLV  one-hot completer select
- PENABLE, PWRITE  out  1  APB enable / direction
- PADDR  out  ADDR_W; PWDATA  out  DATA_W; PSTRB  out  DATA_W/8
- PRDATA  in  NUM_SLV*DATA_W  completer i on bits [i*DATA_W +: DATA_W]
- PREADY, PSLVERR  in  NUM_SLV  per-completer ready / error

## Operation
- States: IDLE, SETUP, ACCESS. All APB and rsp outputs are registered.
- req_ready = 1 in IDLE; in ACCESS = PREADY[sel] (completion cycle); 0 in SETUP.
- Accept: sel = req_addr[SEL_LSB +: SEL_W]. If sel < NUM_SLV: latch addr/wdata/strb/write/sel, go SETUP. Else decode error: no APB activity, stay IDLE, rsp_valid=1, rsp_err=1 next cycle.
- SETUP: PSEL[sel]=1, PENABLE=0, PADDR/PWRITE/PWDATA valid; PSTRB = latched strb for writes, all-0 for reads. Always -> ACCESS.
- ACCESS: PENABLE=1, address/control held stable. PREADY[sel]=1 completes: capture PRDATA slice (reads) and PSLVERR[sel]; then SETUP if a new request is accepted in that cycle, else IDLE (PSEL=0, PENABLE=0).
- PREADY/PSLVERR/PRDATA of unselected completers ignored.
- Timeout: wait counter cleared on entering ACCESS, +1 per ACCESS cycle with PREADY low. When counter reaches TIMEOUT-1 with PREADY low: abort to IDLE, rsp_err=1, rsp_rdata=0; req_ready stays 0 in that cycle.
- Reset (reset_n=0 at edge): state IDLE, PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PSTRB=0, PWRITE=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0. Reset mid-transfer drops the transfer silently, no response.

## Timing
- Accept at edge 0 -> SETUP cycle 1 -> ACCESS cycle 2; zero-wait completion -> rsp_valid in cycle 3. Latency = 3 + wait states.
- Back-to-back: new SETUP in cycle 3, concurrent with prior rsp_valid; throughput one transfer per 2 cycles.
- Decode error: rsp_valid in cycle after accept; consecutive decode errors accepted every cycle.
- Timeout with TIMEOUT=N: abort after N ACCESS cycles; rsp_valid in next cycle.
- rsp_valid high exactly one cycle per accepted request, in request order.

## Structure
- Shared package apb_pkg: state enum apb_state_t {IDLE, SETUP, ACCESS}, APB protocol constants.
- One sub-module: apb_wait_timer (clear, count-enable, TIMEOUT parameter, expired output).

## Test plan
- Write addr 0x1000_0010, data 0xDEADBEEF, strb 0xF, completer 1 PREADY=1 -> PSEL=0b0010 cycles 1-2, PENABLE only cycle 2, rsp_valid cycle 3 err=0.
- Read addr 0x2000_0004, completer 2 PREADY low 3 cycles, PRDATA 0x1234_5678 -> PSTRB=0, rsp_rdata=0x1234_5678 at cycle 6.
- Two requests held valid back-to-back -> no IDLE between; second SETUP coincides with first rsp_valid.
- Addr 0x5000_0000 (sel=5 >= NUM_SLV) -> PSEL stays 0, rsp_valid+rsp_err next cycle; PSLVERR=1 on completer 0 -> rsp_err=1, rdata=0.
- PREADY held low, TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_err=1; reset_n low in ACCESS -> all outputs 0 next edge, no rsp_valid.
